// File: rtl/pc_call_stack_pkg.sv
// Shared definitions for the program counter with call/return stack:
// the one-hot-priority action encoding and its decoder.
package pc_call_stack_pkg;

   localparam int PC_WIDTH = 16;

   typedef enum logic [2:0] {
      ACT_HOLD  = 3'd0,
      ACT_INC   = 3'd1,
      ACT_RET   = 3'd2,
      ACT_CALL  = 3'd3,
      ACT_LOAD  = 3'd4,
      ACT_RESET = 3'd5
   } action_t;

   // Exactly one action per edge: reset > load > call > ret > inc > hold.
   function automatic action_t decode_action(input logic reset,
                                             input logic load,
                                             input logic call,
                                             input logic ret,
                                             input logic inc);
      action_t a;
      a = ACT_HOLD;
      if (reset)     a = ACT_RESET;
      else if (load) a = ACT_LOAD;
      else if (call) a = ACT_CALL;
      else if (ret)  a = ACT_RET;
      else if (inc)  a = ACT_INC;
      return a;
   endfunction

endpackage

// File: rtl/pc_return_stack.sv
// WIDTH x DEPTH LIFO of return addresses. dout always shows the top entry;
// synchronous reset clears only the stack pointer.
module pc_return_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     sp,
   output logic                       full,
   output logic                       empty
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SPW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_idx;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // DEPTH is a power of two, so the low bits of sp-1 address the top entry
   // even when sp == DEPTH.
   assign rd_idx = sp[AW-1:0] - AW'(1);
   assign dout   = mem[rd_idx];
   assign full   = (sp == SPW'(DEPTH));
   assign empty  = (sp == '0);

   // NOTE: the storage array has no reset; entries above sp are never read,
   // so clearing them would only cost logic.
   always_ff @(posedge clock) begin
      if (!reset && push_ok) mem[sp[AW-1:0]] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clock) begin
      if (reset)        sp <= '0;
      else if (push_ok) sp <= sp + SPW'(1);
      else if (pop_ok)  sp <= sp - SPW'(1);
   end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with load, increment and call/return through an internal
// return-address stack. Every command takes effect on the next clock edge.
module pc_call_stack
   import pc_call_stack_pkg::*;
#(
   parameter int WIDTH        = PC_WIDTH,
   parameter int DEPTH        = 8,
   parameter int STEP         = 1,
   parameter int RESET_VECTOR = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in,
   input  logic                   load,
   input  logic                   call,
   input  logic                   ret,
   input  logic                   inc,
   output logic [WIDTH-1:0]       out,
   output logic [$clog2(DEPTH):0] sp,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   output logic                   underflow
);

   action_t          action;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] next_seq;
   logic [WIDTH-1:0] ret_addr;

   // NOTE: always_comb outputs get a value on every path, so no latch forms.
   always_comb begin
      action = decode_action(reset, load, call, ret, inc);
   end

   assign next_seq = out + WIDTH'(STEP);
   assign push     = (action == ACT_CALL) && !full;
   assign pop      = (action == ACT_RET) && !empty;

   pc_return_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (next_seq),
      .dout  (ret_addr),
      .sp    (sp),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         out       <= WIDTH'(RESET_VECTOR);
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         case (action)
            ACT_LOAD: out <= in;
            ACT_CALL: begin
               if (full) overflow <= 1'b1;
               else      out      <= in;
            end
            ACT_RET: begin
               if (empty) underflow <= 1'b1;
               else       out       <= ret_addr;
            end
            ACT_INC: out <= next_seq;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack: directed scenarios plus randomized
// commands against a queue-based reference model; a second instance uses
// STEP=2 and RESET_VECTOR=0x0040.
module tb_pc_call_stack;

   logic        clock = 1'b0;
   int          n_tests = 0;
   int          n_fail  = 0;

   // Instance A: WIDTH=16, DEPTH=4, STEP=1, RESET_VECTOR=0
   logic        reset_a, load_a, call_a, ret_a, inc_a;
   logic [15:0] in_a, out_a;
   logic [2:0]  sp_a;
   logic        full_a, empty_a, ovf_a, unf_a;

   // Instance B: WIDTH=16, DEPTH=4, STEP=2, RESET_VECTOR=0x0040
   logic        reset_b, load_b, call_b, ret_b, inc_b;
   logic [15:0] in_b, out_b;
   logic [2:0]  sp_b;
   logic        full_b, empty_b, ovf_b, unf_b;

   // Reference model for instance A
   logic [15:0] m_out;
   logic [15:0] m_stk[$];
   logic        m_ovf, m_unf;

   always #5 clock = ~clock;

   pc_call_stack #(.WIDTH(16), .DEPTH(4), .STEP(1), .RESET_VECTOR(0)) dut_a (
      .clock(clock), .reset(reset_a), .in(in_a), .load(load_a), .call(call_a),
      .ret(ret_a), .inc(inc_a), .out(out_a), .sp(sp_a), .full(full_a),
      .empty(empty_a), .overflow(ovf_a), .underflow(unf_a));

   pc_call_stack #(.WIDTH(16), .DEPTH(4), .STEP(2), .RESET_VECTOR(16'h0040)) dut_b (
      .clock(clock), .reset(reset_b), .in(in_b), .load(load_b), .call(call_b),
      .ret(ret_b), .inc(inc_b), .out(out_b), .sp(sp_b), .full(full_b),
      .empty(empty_b), .overflow(ovf_b), .underflow(unf_b));

   // Drive one command into instance A, clock it, and advance the model.
   task automatic step_a(input logic r, input logic l, input logic c,
                         input logic rt, input logic i, input logic [15:0] d);
      reset_a = r; load_a = l; call_a = c; ret_a = rt; inc_a = i; in_a = d;
      @(posedge clock);
      #1;
      if (r) begin
         m_out = 16'h0000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end else if (l) begin
         m_out = d;
      end else if (c) begin
         if (m_stk.size() == 4) m_ovf = 1'b1;
         else begin m_stk.push_back(m_out + 16'd1); m_out = d; end
      end else if (rt) begin
         if (m_stk.size() == 0) m_unf = 1'b1;
         else m_out = m_stk.pop_back();
      end else if (i) begin
         m_out = m_out + 16'd1;
      end
      reset_a = 0; load_a = 0; call_a = 0; ret_a = 0; inc_a = 0;
   endtask

   task automatic step_b(input logic r, input logic l, input logic c,
                         input logic rt, input logic i, input logic [15:0] d);
      reset_b = r; load_b = l; call_b = c; ret_b = rt; inc_b = i; in_b = d;
      @(posedge clock);
      #1;
      reset_b = 0; load_b = 0; call_b = 0; ret_b = 0; inc_b = 0;
   endtask

   task automatic test_reset();
      step_a(1, 0, 0, 0, 0, 16'h1234);
      n_tests++;
      if (out_a !== 16'h0000 || sp_a !== 3'd0 || empty_a !== 1'b1 ||
          full_a !== 1'b0 || ovf_a !== 1'b0 || unf_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: out=%h sp=%0d empty=%b full=%b ovf=%b unf=%b, required out=0000 sp=0 empty=1 full=0 ovf=0 unf=0",
                  out_a, sp_a, empty_a, full_a, ovf_a, unf_a);
      end
   endtask

   task automatic test_load_inc();
      logic [15:0] exp_seq [3];
      exp_seq[0] = 16'h0010; exp_seq[1] = 16'h0011; exp_seq[2] = 16'h0012;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) step_a(0, 1, 0, 0, 0, 16'h0010);
         else        step_a(0, 0, 0, 0, 1, 16'h0000);
         n_tests++;
         if (out_a !== exp_seq[k] || sp_a !== 3'd0) begin
            n_fail++;
            $display("FAIL load_inc[%0d]: out=%h sp=%0d, required out=%h sp=0",
                     k, out_a, sp_a, exp_seq[k]);
         end
      end
   endtask

   task automatic test_call_ret();
      step_a(0, 0, 1, 0, 0, 16'h0100);
      n_tests++;
      if (out_a !== 16'h0100 || sp_a !== 3'd1 || empty_a !== 1'b0) begin
         n_fail++;
         $display("FAIL call: out=%h sp=%0d empty=%b, required out=0100 sp=1 empty=0",
                  out_a, sp_a, empty_a);
      end
      step_a(0, 0, 0, 0, 1, 16'h0000);
      n_tests++;
      if (out_a !== 16'h0101) begin
         n_fail++;
         $display("FAIL inc_in_callee: out=%h, required 0101", out_a);
      end
      step_a(0, 0, 0, 1, 0, 16'h0000);
      n_tests++;
      if (out_a !== 16'h0013 || sp_a !== 3'd0 || empty_a !== 1'b1) begin
         n_fail++;
         $display("FAIL ret: out=%h sp=%0d empty=%b, required out=0013 sp=0 empty=1",
                  out_a, sp_a, empty_a);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] targets [4];
      logic [15:0] rets    [4];
      targets[0] = 16'h0200; targets[1] = 16'h0300;
      targets[2] = 16'h0400; targets[3] = 16'h0500;
      // Popped in LIFO order: last pushed return address first.
      rets[0] = 16'h0401; rets[1] = 16'h0301; rets[2] = 16'h0201; rets[3] = 16'h0014;
      for (int k = 0; k < 4; k++) step_a(0, 0, 1, 0, 0, targets[k]);
      n_tests++;
      if (sp_a !== 3'd4 || full_a !== 1'b1 || out_a !== 16'h0500 || ovf_a !== 1'b0) begin
         n_fail++;
         $display("FAIL nested_calls: sp=%0d full=%b out=%h ovf=%b, required sp=4 full=1 out=0500 ovf=0",
                  sp_a, full_a, out_a, ovf_a);
      end
      step_a(0, 0, 1, 0, 0, 16'h0AAA);
      n_tests++;
      if (out_a !== 16'h0500 || sp_a !== 3'd4 || ovf_a !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow: out=%h sp=%0d ovf=%b, required out=0500 sp=4 ovf=1",
                  out_a, sp_a, ovf_a);
      end
      for (int k = 0; k < 4; k++) begin
         step_a(0, 0, 0, 1, 0, 16'h0000);
         n_tests++;
         if (out_a !== rets[k] || sp_a !== 3'(3 - k) || ovf_a !== 1'b1) begin
            n_fail++;
            $display("FAIL lifo_ret[%0d]: out=%h sp=%0d ovf=%b, required out=%h sp=%0d ovf=1",
                     k, out_a, sp_a, ovf_a, rets[k], 3 - k);
         end
      end
   endtask

   task automatic test_underflow();
      step_a(0, 0, 0, 1, 0, 16'h0000);
      n_tests++;
      if (out_a !== 16'h0014 || sp_a !== 3'd0 || unf_a !== 1'b1) begin
         n_fail++;
         $display("FAIL underflow: out=%h sp=%0d unf=%b, required out=0014 sp=0 unf=1",
                  out_a, sp_a, unf_a);
      end
      step_a(0, 0, 0, 0, 1, 16'h0000);
      n_tests++;
      if (out_a !== 16'h0015 || unf_a !== 1'b1) begin
         n_fail++;
         $display("FAIL inc_after_underflow: out=%h unf=%b, required out=0015 unf=1",
                  out_a, unf_a);
      end
   endtask

   task automatic test_priority();
      step_a(0, 1, 0, 0, 0, 16'hFFFF);
      step_a(0, 0, 0, 0, 1, 16'h0000);
      n_tests++;
      if (out_a !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap: out=%h, required 0000", out_a);
      end
      step_a(0, 1, 1, 0, 1, 16'h0050);
      n_tests++;
      if (out_a !== 16'h0050 || sp_a !== 3'd0) begin
         n_fail++;
         $display("FAIL load_beats_call: out=%h sp=%0d, required out=0050 sp=0",
                  out_a, sp_a);
      end
      step_a(0, 0, 1, 1, 1, 16'h0060);
      n_tests++;
      if (out_a !== 16'h0060 || sp_a !== 3'd1) begin
         n_fail++;
         $display("FAIL call_beats_ret: out=%h sp=%0d, required out=0060 sp=1",
                  out_a, sp_a);
      end
      step_a(0, 0, 0, 1, 1, 16'h0000);
      n_tests++;
      if (out_a !== 16'h0051 || sp_a !== 3'd0) begin
         n_fail++;
         $display("FAIL ret_beats_inc: out=%h sp=%0d, required out=0051 sp=0",
                  out_a, sp_a);
      end
      step_a(1, 0, 1, 0, 0, 16'h0070);
      n_tests++;
      if (out_a !== 16'h0000 || sp_a !== 3'd0 || ovf_a !== 1'b0 || unf_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_beats_call: out=%h sp=%0d ovf=%b unf=%b, required out=0000 sp=0 ovf=0 unf=0",
                  out_a, sp_a, ovf_a, unf_a);
      end
   endtask

   task automatic test_random();
      logic [3:0] sel;
      for (int k = 0; k < 400; k++) begin
         sel = 4'($urandom_range(0, 15));
         step_a(($urandom_range(0, 59) == 0), (sel == 4'd0),
                (sel >= 4'd1 && sel <= 4'd5) || ($urandom_range(0, 7) == 0),
                (sel >= 4'd6 && sel <= 4'd10) || ($urandom_range(0, 7) == 0),
                (sel >= 4'd11) || ($urandom_range(0, 3) == 0),
                16'($urandom));
         n_tests++;
         if (out_a !== m_out || sp_a !== 3'(m_stk.size()) ||
             full_a !== (m_stk.size() == 4) || empty_a !== (m_stk.size() == 0) ||
             ovf_a !== m_ovf || unf_a !== m_unf) begin
            n_fail++;
            $display("FAIL random[%0d]: out=%h sp=%0d full=%b empty=%b ovf=%b unf=%b, required out=%h sp=%0d ovf=%b unf=%b",
                     k, out_a, sp_a, full_a, empty_a, ovf_a, unf_a,
                     m_out, m_stk.size(), m_ovf, m_unf);
         end
      end
   endtask

   task automatic test_step2();
      step_b(1, 0, 0, 0, 0, 16'h0000);
      n_tests++;
      if (out_b !== 16'h0040 || sp_b !== 3'd0 || empty_b !== 1'b1) begin
         n_fail++;
         $display("FAIL s2_reset: out=%h sp=%0d empty=%b, required out=0040 sp=0 empty=1",
                  out_b, sp_b, empty_b);
      end
      step_b(0, 1, 0, 0, 0, 16'h0010);
      step_b(0, 0, 0, 0, 1, 16'h0000);
      step_b(0, 0, 0, 0, 1, 16'h0000);
      n_tests++;
      if (out_b !== 16'h0014) begin
         n_fail++;
         $display("FAIL s2_load_inc: out=%h, required 0014", out_b);
      end
      step_b(1, 0, 0, 0, 0, 16'h0000);
      step_b(0, 0, 1, 0, 0, 16'h0100);
      n_tests++;
      if (out_b !== 16'h0100 || sp_b !== 3'd1 || full_b !== 1'b0) begin
         n_fail++;
         $display("FAIL s2_call: out=%h sp=%0d full=%b, required out=0100 sp=1 full=0",
                  out_b, sp_b, full_b);
      end
      step_b(0, 0, 0, 0, 1, 16'h0000);
      step_b(0, 0, 0, 1, 0, 16'h0000);
      n_tests++;
      if (out_b !== 16'h0042 || sp_b !== 3'd0 || empty_b !== 1'b1 ||
          ovf_b !== 1'b0 || unf_b !== 1'b0) begin
         n_fail++;
         $display("FAIL s2_ret: out=%h sp=%0d empty=%b ovf=%b unf=%b, required out=0042 sp=0 empty=1 ovf=0 unf=0",
                  out_b, sp_b, empty_b, ovf_b, unf_b);
      end
   endtask

   initial begin
      reset_a = 1; load_a = 0; call_a = 0; ret_a = 0; inc_a = 0; in_a = '0;
      reset_b = 1; load_b = 0; call_b = 0; ret_b = 0; inc_b = 0; in_b = '0;
      m_out = '0; m_ovf = 0; m_unf = 0;
      #2;
      test_reset();
      test_load_inc();
      test_call_ret();
      test_overflow();
      test_underflow();
      test_priority();
      test_random();
      test_step2();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
